hsv2rgb_sched: RTL
==================

Name: hsv2rgb_sched

Overview:
- Shares one pipelined hsv2rgb converter among NREQ pixel requesters, e.g. the overlay, sticker and filter paths in the passport pipeline.
- Arbitrates round-robin with a burst limit and launches one HSV triple per cycle into the converter.
- Tracks each launch through the converter latency and returns the RGB result to the requester that issued it.
- Sits between the per-path colour logic and the single hsv2rgb instance. The converter is instantiated beside this block, not inside it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 3, converter clock latency: edges from cv_h/s/v change to matching cv_r/g/b.
- BURST, 4, maximum consecutive beats one requester keeps the grant while others wait (>=1).
- IDW, 2, width of the owner index, equal to clog2(NREQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester HSV beat valid.
- req_h  in  8*NREQ  hue; requester i occupies bits [8i+7:8i]. Same layout for req_s and req_v.
- req_s  in  8*NREQ  saturation.
- req_v  in  8*NREQ  value.
- req_ready  out  NREQ  one-hot accept. Combinational, at most one bit high.
- cv_h, cv_s, cv_v  out  8 each  registered operands to the converter.
- cv_r, cv_g, cv_b  in  8 each  converter results.
- res_valid  out  NREQ  one-hot; result belongs to this requester.
- res_r, res_g, res_b  out  8 each  cv_r/g/b passed through.
- busy  out  1  a launch is in flight or accepted this cycle.

Behaviour:
Reset (rst=0, asynchronous):
- cv_h/s/v = 0, tag pipeline cleared, owner pointer = 0, burst count = 0, state IDLE.
- req_ready = 0, res_valid = 0 and busy = 0 while rst is low.

Handshake:
- A beat transfers on a rising edge when req_valid[i] and req_ready[i] are both high.
- Requester data must be held until accepted.
- req_ready depends only on req_valid and state; there is no combinational path from cv_* inputs.

State machine:
- IDLE: no owner. If any req_valid, grant the first valid requester searching upward from pointer+1 (wrapping) → OWNED, cnt = 0.
- OWNED(owner, cnt):
  - Keep the owner if req_valid[owner] and (cnt < BURST-1 or no other requester valid). Increment cnt, saturating at BURST-1.
  - Otherwise rotate: grant the next valid requester after owner (wrapping), set cnt = 0, pointer = new owner.
  - If no requester is valid → IDLE; pointer keeps the last owner.
- BURST = 1 gives pure round-robin. Any requester with valid held is granted within (NREQ-1)*BURST cycles.

Launch:
- On an accept edge, cv_h/s/v load the granted triple. A tag {valid, owner} enters a LATENCY+1-deep shift register.
- With no accept, cv_* hold their previous value and a bubble tag (valid = 0) enters.

Return:
- The tail tag drives res_valid = one-hot(owner) when its valid bit is set. res_r/g/b = cv_r/g/b.
- Accept edge k gives res_valid high during cycle k+LATENCY+1 (the cycle after edge k+LATENCY).
- Back-to-back accepts give back-to-back results in issue order.
- Results cannot be stalled; requesters must take them in that cycle.

Boundaries:
- Simultaneous requests: only the granted requester sees ready; the others wait.
- Owner drops valid mid-burst: rotation happens that same cycle with no bubble when another requester is valid.
- Reset mid-operation: in-flight tags are discarded and no res_valid is produced for them, even though the converter still emits data.
- Pointer wraps from NREQ-1 to 0.

Decomposition:
- Shared package hsv_pkg holds:
  - pixel-component width 8;
  - the tag struct {valid, owner[IDW-1:0]};
  - a function onehot(owner) returning NREQ bits.
- One sub-module, rr_burst_arb: the IDLE/OWNED FSM, pointer and burst counter. Its outputs are the grant vector and the owner index.
- The tag shift register and operand registers stay in the top module.

Test Plan (LATENCY=3, BURST=4, NREQ=4, real hsv2rgb attached):
- Req0 single beat, h=0 s=0 v=255, accepted at edge 0 → res_valid=4'b0001 only in cycle 4, with r=g=b=255. busy is high cycles 0-4, then low.
- Req0 and req2 both held valid for 12 beats → grants go req0×4, req2×4, req0×4. Results return in issue order, tagged 0001/0100 with 4-beat spacing; h=0 s=0 v=100 gives r=g=b=100.
- All four requesters valid, BURST=1 build → grants rotate 0,1,2,3,0 on consecutive edges. req_ready is never multi-hot. The pointer wraps.
- Req1 drops valid after 2 beats while req3 is valid → req3 is granted on the next edge with no bubble. cnt restarts at 0.
- rst pulsed low 2 cycles after 3 accepts → no res_valid appears for the discarded beats. cv_* = 0 and state is IDLE. A new req0 beat returns 4 cycles after its accept.
- No requests for 10 cycles → req_ready=0, res_valid=0, busy=0, and cv_* hold their last value.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared types for the hsv2rgb request scheduler: component width,
// in-flight tag layout and the owner one-hot decoder.
package hsv_pkg;

    localparam int COMP_W  = 8;
    localparam int MAX_REQ = 8;
    localparam int OWNER_W = 3;

    // Owner field sized for the largest supported requester count.
    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [OWNER_W-1:0] owner);
        return MAX_REQ'(1) << owner;
    endfunction

endpackage

// File: rtl/rr_burst_arb.sv
// Round-robin arbiter with a per-owner burst limit. The grant is a
// combinational function of req_valid and the registered owner state.
module rr_burst_arb
    import hsv_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    parameter int IDW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_t     state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;

    logic [NREQ-1:0] own_mask;
    logic            others;
    logic            keep;
    logic            rot_any;
    logic [IDW-1:0]  rot_idx;
    logic            any_next;
    logic [IDW-1:0]  idx_next;

    // First valid requester strictly after base, wrapping; base itself is last.
    function automatic logic [IDW:0] next_valid(input logic [NREQ-1:0] v,
                                                input logic [IDW-1:0]  base);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(base) + off) % NREQ;
            if (v[idx]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    always_comb begin
        own_mask           = NREQ'(onehot(OWNER_W'(ptr)));
        others             = |(req_valid & ~own_mask);
        keep               = (state == ARB_OWNED) && req_valid[ptr] &&
                             ((int'(cnt) < BURST - 1) || !others);
        {rot_any, rot_idx} = next_valid(req_valid, ptr);
        any_next           = keep || rot_any;
        idx_next           = keep ? ptr : rot_idx;
    end

    // Nothing is granted while reset is held.
    assign grant_any = rst && any_next;
    assign grant_idx = idx_next;
    assign grant     = grant_any ? NREQ'(onehot(OWNER_W'(idx_next))) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else if (any_next) begin
            state <= ARB_OWNED;
            ptr   <= idx_next;
            if (keep)
                cnt <= (int'(cnt) < BURST - 1) ? cnt + CW'(1) : cnt;
            else
                cnt <= '0;
        end else begin
            state <= ARB_IDLE;
            cnt   <= '0;
        end
    end

endmodule

// File: rtl/hsv2rgb_sched.sv
// Shares one pipelined hsv2rgb converter among NREQ requesters and routes
// each result back to its issuer using a tag pipeline matched to the latency.
module hsv2rgb_sched
    import hsv_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    parameter int BURST   = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [COMP_W*NREQ-1:0] req_h,
    input  logic [COMP_W*NREQ-1:0] req_s,
    input  logic [COMP_W*NREQ-1:0] req_v,
    output logic [NREQ-1:0]        req_ready,
    output logic [COMP_W-1:0]      cv_h,
    output logic [COMP_W-1:0]      cv_s,
    output logic [COMP_W-1:0]      cv_v,
    input  logic [COMP_W-1:0]      cv_r,
    input  logic [COMP_W-1:0]      cv_g,
    input  logic [COMP_W-1:0]      cv_b,
    output logic [NREQ-1:0]        res_valid,
    output logic [COMP_W-1:0]      res_r,
    output logic [COMP_W-1:0]      res_g,
    output logic [COMP_W-1:0]      res_b,
    output logic                   busy
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;

    rr_burst_arb #(
        .NREQ  (NREQ),
        .BURST (BURST),
        .IDW   (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cv_h <= '0;
            cv_s <= '0;
            cv_v <= '0;
        end else if (grant_any) begin
            cv_h <= req_h[int'(grant_idx)*COMP_W +: COMP_W];
            cv_s <= req_s[int'(grant_idx)*COMP_W +: COMP_W];
            cv_v <= req_v[int'(grant_idx)*COMP_W +: COMP_W];
        end
    end

    // Stage LATENCY lines up with the converter output for the same launch.
    tag_t tag_in;
    tag_t tag_pipe [LATENCY+1];

    always_comb begin
        tag_in.valid = grant_any;
        tag_in.owner = OWNER_W'(grant_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i <= LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    logic [LATENCY:0] inflight;

    generate
        for (genvar gi = 0; gi <= LATENCY; gi++) begin : g_inflight
            assign inflight[gi] = tag_pipe[gi].valid;
        end
    endgenerate

    assign busy      = grant_any || (|inflight);
    assign res_valid = tag_pipe[LATENCY].valid ?
                       NREQ'(onehot(tag_pipe[LATENCY].owner)) : '0;
    assign res_r     = cv_r;
    assign res_g     = cv_g;
    assign res_b     = cv_b;

endmodule
